// File: rtl/chunked_adder_acc_if.sv
// chunked_adder_acc_if: operand/result valid-ready bundle for the chunked adder
interface chunked_adder_acc_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, cin, sub, acc;
  logic out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] a, b, s;
  modport master(output in_valid, a, b, cin, sub, acc, out_ready,
                 input in_ready, out_valid, s, cout, ovf);
  modport slave(input in_valid, a, b, cin, sub, acc, out_ready,
                output in_ready, out_valid, s, cout, ovf);
endinterface

// File: rtl/chunked_adder_acc.sv
// chunked_adder_acc: CHUNK-bits-per-cycle add/sub/accumulate; define ADDER_BCD_EN for decimal digits
module chunked_adder_acc #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic rst_n,
  chunked_adder_acc_if.slave bus
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, st_nx;
  logic [WIDTH-1:0] opa, opb, s, bneg;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] ca, cb, dig;
  logic [CHUNK:0] sum;
  logic carry, cnx, cout, ovf, last;
  if (WIDTH % CHUNK != 0) begin : g_width_chk
    $error("WIDTH must be a multiple of CHUNK");
  end
`ifdef ADDER_BCD_EN
  if (CHUNK != 4) begin : g_chunk_chk
    $error("CHUNK must be 4 when ADDER_BCD_EN is defined");
  end
`endif
  always_comb begin
    ca = opa[idx*CHUNK +: CHUNK];
    cb = opb[idx*CHUNK +: CHUNK];
    last = idx == IW'(N - 1);
    sum = {1'b0, ca} + {1'b0, cb} + (CHUNK+1)'(carry);
    bneg = '0;
`ifdef ADDER_BCD_EN
    cnx = sum > (CHUNK+1)'(9);
    dig = cnx ? CHUNK'(sum + (CHUNK+1)'(6)) : sum[CHUNK-1:0];
    for (int i = 0; i < N; i++) bneg[i*4 +: 4] = 4'd9 - bus.b[i*4 +: 4];
`else
    cnx = sum[CHUNK];
    dig = sum[CHUNK-1:0];
    bneg = ~bus.b;
`endif
  end
  always_comb begin
    st_nx = st == IDLE ? (bus.in_valid ? RUN : IDLE)
          : st == RUN  ? (last ? DONE : RUN)
          : (bus.out_ready ? IDLE : DONE);
    bus.in_ready = st == IDLE && rst_n;
    bus.out_valid = st == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      opa <= '0;
      opb <= '0;
      carry <= 1'b0;
      idx <= '0;
      s <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      st <= st_nx;
      if (st == IDLE && bus.in_valid) begin
        opa <= bus.acc ? s : bus.a;
        opb <= bus.sub ? bneg : bus.b;
        carry <= bus.sub | bus.cin;
        idx <= '0;
      end else if (st == RUN) begin
        s[idx*CHUNK +: CHUNK] <= dig;
        carry <= cnx;
        idx <= idx + 1'b1;
        if (last) begin
          cout <= cnx;
`ifdef ADDER_BCD_EN
          ovf <= 1'b0;
`else
          ovf <= (opa[WIDTH-1] == opb[WIDTH-1]) && (dig[CHUNK-1] != opa[WIDTH-1]);
`endif
        end
      end
    end
  end
  assign bus.s = s;
  assign bus.cout = cout;
  assign bus.ovf = ovf;
endmodule

// File: tb/tb_chunked_adder_acc.sv
// tb_chunked_adder_acc: directed vectors for the chunked adder/accumulator
module tb_chunked_adder_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  chunked_adder_acc_if #(.WIDTH(16)) bus();
  chunked_adder_acc #(.WIDTH(16), .CHUNK(4)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic cin, input logic sub, input logic acc,
                    input logic [15:0] es, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    check({tag, ".rdy"}, 32'(bus.in_ready), 1);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.sub = sub;
    bus.acc = acc;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, ".lat"}, 32'(n), 4);
    check({tag, ".s"}, 32'(bus.s), 32'(es));
    check({tag, ".cout"}, 32'(bus.cout), 32'(ec));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
    @(posedge clk);
    #1 check({tag, ".ovld0"}, 32'(bus.out_valid), 0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus.acc = 1'b0;
    #1;
    check("rst.rdy", 32'(bus.in_ready), 0);
    check("rst.s", 32'(bus.s), 0);
    check("rst.ovld", 32'(bus.out_valid), 0);
    check("rst.cout", 32'(bus.cout), 0);
    check("rst.ovf", 32'(bus.ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel.rdy", 32'(bus.in_ready), 1);
`ifdef ADDER_BCD_EN
    op("bcd_add", 16'h0999, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    op("bcd_sub", 16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
`else
    op("add", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op("cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op("acc1", 16'hAAAA, 16'h0100, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    op("acc2", 16'hAAAA, 16'h0100, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0);
    op("acc3", 16'hAAAA, 16'h0100, 1'b0, 1'b0, 1'b1, 16'h0300, 1'b0, 1'b0);
    @(negedge clk);
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.acc = 1'b0;
    bus.sub = 1'b0;
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.a = 16'h4444;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      @(posedge clk);
      #1;
      check($sformatf("stall%0d.ovld", i), 32'(bus.out_valid), 1);
      check($sformatf("stall%0d.s", i), 32'(bus.s), 32'h3333);
      check($sformatf("stall%0d.rdy", i), 32'(bus.in_ready), 0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 check("stall.rel", 32'(bus.out_valid), 0);
    repeat (6) @(posedge clk);
    #1;
    check("stall.nostart", 32'(bus.s), 32'h3333);
    check("stall.idle", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.a = 16'h1234;
    bus.b = 16'h0FFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.s", 32'(bus.s), 0);
    check("arst.ovld", 32'(bus.out_valid), 0);
    check("arst.rdy", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("arst.rel", 32'(bus.in_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    check("arst.nores", 32'(bus.out_valid), 0);
    check("arst.s0", 32'(bus.s), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/chunked_adder_acc.md
# chunked_adder_acc

Parametrised multi-cycle adder/subtractor/accumulator and the successor to the fixed 4-bit combinational adder. It adds a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry through a register between cycles, so wide time-of-day and counter arithmetic fits the Spartan-3 clock design without a long combinational carry chain. Operands come in and results go out over valid/ready handshakes. The result register doubles as an accumulator.

## Interface
- WIDTH, 16, operand/result width; must be an integer multiple of CHUNK
- CHUNK, 4, bits added per cycle; N = WIDTH/CHUNK cycles per operation
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand transfer request
- in_ready  output  1  block can accept operands (IDLE only)
- a  input  WIDTH  operand A (ignored when acc=1)
- b  input  WIDTH  operand B
- cin  input  1  carry in (ignored when sub=1)
- sub  input  1  1: A − B, 0: A + B + cin
- acc  input  1  1: use current s as operand A
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  result / accumulator register
- cout  output  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

## Operation
- One clock, asynchronous active-low reset.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch opa = acc ? s : a, opb = sub ? ~b : b, and carry = sub ? 1 : cin. Clear idx, then go to RUN.
  - RUN: each cycle, {carry, s[idx*CHUNK +: CHUNK]} = opa chunk + opb chunk + carry, then idx++.
    - On the last chunk (idx = N−1), register cout = final carry and ovf = (opa MSB == opb MSB) && (s MSB != opa MSB), then go to DONE.
  - DONE: out_valid=1; s, cout and ovf are held stable. On out_ready, go to IDLE.
- s is not cleared on return to IDLE. It keeps the last result, which serves as the accumulator value.
- cout and ovf also hold until the next operation completes.
- Inputs a, b, cin, sub and acc are sampled only on the accepting edge. Changes during RUN or DONE have no effect.
- in_valid outside IDLE is ignored. out_ready outside DONE is ignored.
- The result is modulo 2^WIDTH; there is no saturation.
- The chunk holding partial results in s is overwritten during RUN. Consumers must read s only while out_valid=1.

## Timing
- Reset value of all outputs is 0: in_ready=0 while rst_n is low, 1 after release (state IDLE, s=0, cout=0, ovf=0, out_valid=0).
- Latency: an operand is accepted on edge T0. out_valid rises after edge T0+N and stays high until the edge where out_ready=1.
- With out_ready tied high, throughput is one operation per N+2 cycles.
- Reset asserted mid-RUN or in DONE: the operation is aborted immediately, all registers return to their reset values, and no result is delivered.

## Configuration
- ADDER_BCD_EN defined: each 4-bit digit is decimal-corrected.
  - CHUNK must equal 4; other values are a synthesis error.
  - Add: if the digit sum exceeds 9, add 6 and set the digit carry.
  - Subtract: opb is the nine's complement of b per digit, with initial carry 1.
  - ovf is tied to 0.
  - Operands must be valid BCD; results for non-BCD inputs are undefined.
- ADDER_BCD_EN undefined: pure binary behaviour as described above.

## Test plan
All cases use WIDTH=16, CHUNK=4.
- Add 0x1234 + 0x0FFF, cin=0, out_ready=1 -> out_valid 4 cycles after accept; s=0x2233, cout=0, ovf=0.
- 0xFFFF + 0x0001 -> s=0x0000, cout=1, ovf=0. 0x7FFF + 0x0001 -> s=0x8000, cout=0, ovf=1.
- sub: 0x0005 − 0x0007 -> s=0xFFFE, cout=0. 0x0007 − 0x0005 -> s=0x0002, cout=1.
- After reset, three transactions with acc=1, b=0x0100, a=0xAAAA -> s=0x0100, then 0x0200, then 0x0300.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> out_valid, s and cout stay stable; in_ready=0; no new operation starts.
- Drop rst_n in the 2nd RUN cycle -> s=0, out_valid=0 asynchronously; in_ready=1 after release. With ADDER_BCD_EN: 0x0999 + 0x0001 -> s=0x1000, cout=0.
